// File: rtl/aes_ctr_pkg.sv
// Shared widths, default timing constants and the controller state encoding
// for the AES-CTR stream controller.
package aes_ctr_pkg;

    localparam int unsigned KEYLEN         = 128;
    localparam int unsigned TIMEOUT_CYCLES = 64;
    localparam int unsigned NBLK_W         = 16;
    localparam int unsigned RUN_CYCLES     = 2;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_ARM  = 3'd1,
        ST_RUN  = 3'd2,
        ST_WAIT = 3'd3,
        ST_EMIT = 3'd4,
        ST_ERR  = 3'd5
    } ctrl_state_t;

endpackage

// File: rtl/aes_ctr_stream_ctrl_if.sv
// Session config, block streams and core-side signals of the AES-CTR stream controller.
// The controller takes the slave modport; the environment (host + core) takes master.
interface aes_ctr_stream_ctrl_if #(
    parameter int unsigned KEYLEN = aes_ctr_pkg::KEYLEN
);
    localparam int unsigned HALF   = KEYLEN / 2;
    localparam int unsigned NBLK_W = aes_ctr_pkg::NBLK_W;

    logic              cfg_valid;
    logic              cfg_ready;
    logic              cfg_encNotDec;
    logic [KEYLEN-1:0] cfg_key;
    logic [HALF-1:0]   cfg_nonce;
    logic [HALF-1:0]   cfg_counter;
    logic [NBLK_W-1:0] cfg_nblocks;
    logic              abort;

    logic              in_valid;
    logic              in_ready;
    logic [KEYLEN-1:0] in_data;

    logic              out_valid;
    logic              out_ready;
    logic [KEYLEN-1:0] out_data;
    logic              out_last;

    logic              core_rst;
    logic              core_encNotDec;
    logic [KEYLEN-1:0] core_key;
    logic [HALF-1:0]   core_nonce;
    logic [HALF-1:0]   core_counterIn;
    logic [KEYLEN-1:0] core_messageIn;
    logic [KEYLEN-1:0] core_cipherIn;
    logic              core_done_message;
    logic              core_done_cipher;
    logic [KEYLEN-1:0] core_messageOut;
    logic [KEYLEN-1:0] core_cipherOut;

    logic              busy;
    logic              err_timeout;
    logic              err_wrap;

    modport slave (
        input  cfg_valid, cfg_encNotDec, cfg_key, cfg_nonce, cfg_counter, cfg_nblocks, abort,
        input  in_valid, in_data, out_ready,
        input  core_done_message, core_done_cipher, core_messageOut, core_cipherOut,
        output cfg_ready, in_ready, out_valid, out_data, out_last,
        output core_rst, core_encNotDec, core_key, core_nonce, core_counterIn,
        output core_messageIn, core_cipherIn, busy, err_timeout, err_wrap
    );

    modport master (
        output cfg_valid, cfg_encNotDec, cfg_key, cfg_nonce, cfg_counter, cfg_nblocks, abort,
        output in_valid, in_data, out_ready,
        output core_done_message, core_done_cipher, core_messageOut, core_cipherOut,
        input  cfg_ready, in_ready, out_valid, out_data, out_last,
        input  core_rst, core_encNotDec, core_key, core_nonce, core_counterIn,
        input  core_messageIn, core_cipherIn, busy, err_timeout, err_wrap
    );

endinterface

// File: rtl/aes_ctr_watchdog.sv
// WAIT-phase watchdog: counts enabled cycles since the last clear and flags
// the cycle that is the TIMEOUT_CYCLES-th one.
module aes_ctr_watchdog #(
    parameter int unsigned TIMEOUT_CYCLES = aes_ctr_pkg::TIMEOUT_CYCLES
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expired
);
    localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             r_expired;

    // Saturates at the final cycle so expired stays high until cleared
    always_comb begin
        w_cnt_nxt = r_cnt;
        if (i_clear) begin
            w_cnt_nxt = '0;
        end else if (i_enable && (r_cnt != LAST)) begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt     <= '0;
            r_expired <= 1'b0;
        end else begin
            r_cnt     <= w_cnt_nxt;
            r_expired <= (w_cnt_nxt == LAST);
        end
    end

    assign o_expired = r_expired;

endmodule

// File: rtl/aes_ctr_stream_ctrl.sv
// Session/stream controller wrapping an aes_CTR_mode core: one block per
// ARM -> RUN -> WAIT -> EMIT pass, counter advanced per emitted block.
module aes_ctr_stream_ctrl #(
    parameter int unsigned KEYLEN         = aes_ctr_pkg::KEYLEN,
    parameter int unsigned TIMEOUT_CYCLES = aes_ctr_pkg::TIMEOUT_CYCLES
) (
    input  logic                 clk,
    input  logic                 rst_n,
    aes_ctr_stream_ctrl_if.slave bus
);
    import aes_ctr_pkg::*;

    localparam int unsigned HALF  = KEYLEN / 2;
    localparam int unsigned RUN_W = (RUN_CYCLES > 1) ? $clog2(RUN_CYCLES) : 1;

    ctrl_state_t       r_state;
    ctrl_state_t       w_state_nxt;
    logic [RUN_W-1:0]  r_run_cnt;

    logic              r_enc;
    logic [KEYLEN-1:0] r_key;
    logic [HALF-1:0]   r_nonce;
    logic [HALF-1:0]   r_counter;
    logic [NBLK_W-1:0] r_remaining;
    logic [KEYLEN-1:0] r_block;
    logic [KEYLEN-1:0] r_out_data;

    logic r_cfg_ready, r_in_ready, r_out_valid, r_out_last, r_core_rst, r_busy;
    logic r_err_timeout, r_err_wrap;

    logic w_cfg_hs, w_in_hs, w_out_hs, w_done, w_expired;
    logic w_load_cfg, w_load_blk, w_load_out, w_advance;
    logic w_set_to, w_set_wrap, w_clr_err;

    assign w_cfg_hs = bus.cfg_valid && r_cfg_ready;
    assign w_in_hs  = bus.in_valid  && r_in_ready;
    assign w_out_hs = r_out_valid   && bus.out_ready;
    assign w_done   = r_enc ? bus.core_done_cipher : bus.core_done_message;

    aes_ctr_watchdog #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_clear   (r_state != ST_WAIT),
        .i_enable  (r_state == ST_WAIT),
        .o_expired (w_expired)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state and datapath strobes; abort overrides everything last
    always_comb begin
        w_state_nxt = r_state;
        w_load_cfg  = 1'b0;
        w_load_blk  = 1'b0;
        w_load_out  = 1'b0;
        w_advance   = 1'b0;
        w_set_to    = 1'b0;
        w_set_wrap  = 1'b0;
        w_clr_err   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_cfg_hs) begin
                    w_load_cfg  = 1'b1;
                    w_clr_err   = 1'b1;
                    w_state_nxt = (bus.cfg_nblocks == '0) ? ST_IDLE : ST_ARM;
                end
            end
            ST_ARM: begin
                if (w_in_hs) begin
                    w_load_blk  = 1'b1;
                    w_state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                if (r_run_cnt == RUN_W'(RUN_CYCLES - 1)) begin
                    w_state_nxt = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (w_done) begin
                    w_load_out  = 1'b1;
                    w_state_nxt = ST_EMIT;
                end else if (w_expired) begin
                    w_set_to    = 1'b1;
                    w_state_nxt = ST_ERR;
                end
            end
            ST_EMIT: begin
                if (w_out_hs) begin
                    if ((r_remaining != NBLK_W'(1)) && (&r_counter)) begin
                        w_set_wrap  = 1'b1;
                        w_state_nxt = ST_ERR;
                    end else begin
                        w_advance   = 1'b1;
                        w_state_nxt = (r_remaining == NBLK_W'(1)) ? ST_IDLE : ST_ARM;
                    end
                end
            end
            ST_ERR: begin
                w_state_nxt = ST_ERR;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
        if (bus.abort) begin
            w_state_nxt = ST_IDLE;
            w_load_cfg  = 1'b0;
            w_load_blk  = 1'b0;
            w_load_out  = 1'b0;
            w_advance   = 1'b0;
            w_set_to    = 1'b0;
            w_set_wrap  = 1'b0;
            w_clr_err   = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_run_cnt <= '0;
        end else if ((r_state == ST_RUN) && (w_state_nxt == ST_RUN)) begin
            r_run_cnt <= r_run_cnt + RUN_W'(1);
        end else begin
            r_run_cnt <= '0;
        end
    end

    // Session registers, captured block and result
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_enc       <= 1'b0;
            r_key       <= '0;
            r_nonce     <= '0;
            r_counter   <= '0;
            r_remaining <= '0;
            r_block     <= '0;
            r_out_data  <= '0;
        end else begin
            if (w_load_cfg) begin
                r_enc       <= bus.cfg_encNotDec;
                r_key       <= bus.cfg_key;
                r_nonce     <= bus.cfg_nonce;
                r_counter   <= bus.cfg_counter;
                r_remaining <= bus.cfg_nblocks;
            end
            if (w_load_blk) begin
                r_block <= bus.in_data;
            end
            if (w_load_out) begin
                r_out_data <= r_enc ? bus.core_cipherOut : bus.core_messageOut;
            end
            if (w_advance) begin
                r_counter   <= r_counter + HALF'(1);
                r_remaining <= r_remaining - NBLK_W'(1);
            end
        end
    end

    // Handshake/status outputs registered from the next state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cfg_ready   <= 1'b0;
            r_in_ready    <= 1'b0;
            r_out_valid   <= 1'b0;
            r_out_last    <= 1'b0;
            r_core_rst    <= 1'b1;
            r_busy        <= 1'b0;
            r_err_timeout <= 1'b0;
            r_err_wrap    <= 1'b0;
        end else begin
            r_cfg_ready <= (w_state_nxt == ST_IDLE);
            r_in_ready  <= (w_state_nxt == ST_ARM);
            r_out_valid <= (w_state_nxt == ST_EMIT);
            r_out_last  <= (w_state_nxt == ST_EMIT) && (r_remaining == NBLK_W'(1));
            r_core_rst  <= (w_state_nxt != ST_WAIT);
            r_busy      <= (w_state_nxt != ST_IDLE);
            if (w_clr_err) begin
                r_err_timeout <= 1'b0;
                r_err_wrap    <= 1'b0;
            end else begin
                if (w_set_to) begin
                    r_err_timeout <= 1'b1;
                end
                if (w_set_wrap) begin
                    r_err_wrap <= 1'b1;
                end
            end
        end
    end

    assign bus.cfg_ready      = r_cfg_ready;
    assign bus.in_ready       = r_in_ready;
    assign bus.out_valid      = r_out_valid;
    assign bus.out_data       = r_out_data;
    assign bus.out_last       = r_out_last;
    assign bus.core_rst       = r_core_rst;
    assign bus.core_encNotDec = r_enc;
    assign bus.core_key       = r_key;
    assign bus.core_nonce     = r_nonce;
    assign bus.core_counterIn = r_counter;
    assign bus.core_messageIn = r_block;
    assign bus.core_cipherIn  = r_block;
    assign bus.busy           = r_busy;
    assign bus.err_timeout    = r_err_timeout;
    assign bus.err_wrap       = r_err_wrap;

endmodule

// File: tb/tb_aes_ctr_stream_ctrl.sv
// Directed bench for aes_ctr_stream_ctrl; the bench plays host and AES core,
// supplying hand-known core results and checking controller behaviour.
module tb_aes_ctr_stream_ctrl;

    localparam logic [127:0] KEY   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [63:0]  NONCE = 64'hf0f1f2f3f4f5f6f7;
    localparam logic [63:0]  CTR0  = 64'hf8f9fafbfcfdfeff;
    localparam logic [127:0] PT    = 128'h6bc1bee22e409f96e93d7e117393172a;
    localparam logic [127:0] CT    = 128'h874d6191b620e3261bef6864990db6ce;
    localparam logic [127:0] PT2   = 128'hae2d8a571e03ac9c9eb76fac45af8e51;
    localparam logic [127:0] CT2   = 128'h9806f66b7970fdff8617187bb9fffdff;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_errors;

    aes_ctr_stream_ctrl_if bus ();

    aes_ctr_stream_ctrl dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_b(input string tag, input logic obs, input logic exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic do_cfg(input logic enc, input logic [63:0] ctr, input logic [15:0] nb);
        int n;
        bus.cfg_encNotDec = enc;
        bus.cfg_key       = KEY;
        bus.cfg_nonce     = NONCE;
        bus.cfg_counter   = ctr;
        bus.cfg_nblocks   = nb;
        bus.cfg_valid     = 1'b1;
        n = 0;
        while (!bus.cfg_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        bus.cfg_valid = 1'b0;
        chk_b("cfg_handshake_in_budget", n < 20, 1'b1);
    endtask

    // Sends one block and checks the 3-cycle path to core release
    task automatic start_block(input logic [127:0] din, input logic [63:0] exp_ctr);
        int n;
        bus.in_data  = din;
        bus.in_valid = 1'b1;
        n = 0;
        while (!bus.in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
        chk_b("in_handshake_in_budget", n < 20, 1'b1);
        chk_b("core_rst_run1", bus.core_rst, 1'b1);
        @(negedge clk);
        chk_b("core_rst_run2", bus.core_rst, 1'b1);
        @(negedge clk);
        chk_b("core_rst_released", bus.core_rst, 1'b0);
        chk("core_counterIn", 128'(bus.core_counterIn), 128'(exp_ctr));
        chk("core_messageIn", bus.core_messageIn, din);
        chk("core_cipherIn", bus.core_cipherIn, din);
    endtask

    task automatic run_block(input logic [127:0] din, input logic [63:0] exp_ctr, input logic enc,
                             input logic [127:0] res, input logic exp_last, input int hold);
        logic stable;
        start_block(din, exp_ctr);
        if (enc) begin
            bus.core_done_cipher = 1'b1;
            bus.core_cipherOut   = res;
            bus.core_messageOut  = ~res;
        end else begin
            bus.core_done_message = 1'b1;
            bus.core_messageOut   = res;
            bus.core_cipherOut    = ~res;
        end
        @(negedge clk);
        bus.core_done_cipher  = 1'b0;
        bus.core_done_message = 1'b0;
        chk_b("out_valid_after_done", bus.out_valid, 1'b1);
        chk("out_data", bus.out_data, res);
        chk_b("out_last", bus.out_last, exp_last);
        stable = 1'b1;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            stable = stable & bus.out_valid & (bus.out_data === res) & (bus.out_last === exp_last);
        end
        if (hold > 0) chk_b("out_held_stable", stable, 1'b1);
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        chk_b("out_valid_dropped", bus.out_valid, 1'b0);
    endtask

    task automatic abort_pulse();
        bus.abort = 1'b1;
        @(negedge clk);
        bus.abort = 1'b0;
    endtask

    initial begin
        int n;
        n_checks = 0;
        n_errors = 0;
        rst_n = 1'b0;
        bus.cfg_valid = 1'b0; bus.cfg_encNotDec = 1'b0; bus.cfg_key = '0;
        bus.cfg_nonce = '0; bus.cfg_counter = '0; bus.cfg_nblocks = '0; bus.abort = 1'b0;
        bus.in_valid = 1'b0; bus.in_data = '0; bus.out_ready = 1'b0;
        bus.core_done_message = 1'b0; bus.core_done_cipher = 1'b0;
        bus.core_messageOut = '0; bus.core_cipherOut = '0;

        // Reset state
        repeat (2) @(negedge clk);
        chk_b("rst_cfg_ready", bus.cfg_ready, 1'b0);
        chk_b("rst_core_rst", bus.core_rst, 1'b1);
        chk_b("rst_busy", bus.busy, 1'b0);
        chk_b("rst_out_valid", bus.out_valid, 1'b0);
        chk("rst_out_data", bus.out_data, 128'h0);
        rst_n = 1'b1;
        @(negedge clk);
        chk_b("cfg_ready_after_rst", bus.cfg_ready, 1'b1);

        // Encrypt one block
        do_cfg(1'b1, CTR0, 16'd1);
        chk_b("busy_in_arm", bus.busy, 1'b1);
        chk_b("in_ready_in_arm", bus.in_ready, 1'b1);
        chk_b("cfg_ready_busy", bus.cfg_ready, 1'b0);
        chk("core_key", bus.core_key, KEY);
        chk("core_nonce", 128'(bus.core_nonce), 128'(NONCE));
        chk_b("core_enc", bus.core_encNotDec, 1'b1);
        run_block(PT, CTR0, 1'b1, CT, 1'b1, 0);
        chk_b("enc_back_idle", bus.cfg_ready, 1'b1);
        chk_b("enc_not_busy", bus.busy, 1'b0);

        // Decrypt the same block
        do_cfg(1'b0, CTR0, 16'd1);
        chk_b("core_dec", bus.core_encNotDec, 1'b0);
        run_block(CT, CTR0, 1'b0, PT, 1'b1, 0);
        chk_b("dec_back_idle", bus.cfg_ready, 1'b1);

        // Two blocks with back-pressure on the first
        do_cfg(1'b1, CTR0, 16'd2);
        run_block(PT, CTR0, 1'b1, CT, 1'b0, 5);
        chk_b("rearm_in_ready", bus.in_ready, 1'b1);
        chk_b("rearm_busy", bus.busy, 1'b1);
        run_block(PT2, 64'hf8f9fafbfcfdff00, 1'b1, CT2, 1'b1, 0);
        chk_b("two_blk_idle", bus.cfg_ready, 1'b1);

        // Counter wrap with blocks still pending
        do_cfg(1'b1, 64'hffffffffffffffff, 16'd2);
        run_block(PT, 64'hffffffffffffffff, 1'b1, CT, 1'b0, 0);
        chk_b("wrap_err", bus.err_wrap, 1'b1);
        chk_b("wrap_busy", bus.busy, 1'b1);
        chk_b("wrap_in_ready", bus.in_ready, 1'b0);
        chk_b("wrap_core_rst", bus.core_rst, 1'b1);
        chk_b("wrap_cfg_ready", bus.cfg_ready, 1'b0);
        abort_pulse();
        chk_b("wrap_abort_idle", bus.cfg_ready, 1'b1);
        chk_b("wrap_abort_clr", bus.err_wrap, 1'b0);

        // Core never finishes
        do_cfg(1'b1, CTR0, 16'd1);
        start_block(PT, CTR0);
        chk_b("to_not_yet", bus.err_timeout, 1'b0);
        n = 0;
        while (!bus.err_timeout && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("timeout_wait_cycles", 128'(n), 128'(64));
        chk_b("to_busy", bus.busy, 1'b1);
        chk_b("to_core_rst", bus.core_rst, 1'b1);
        chk_b("to_out_valid", bus.out_valid, 1'b0);
        abort_pulse();
        chk_b("to_abort_clr", bus.err_timeout, 1'b0);
        chk_b("to_abort_idle", bus.cfg_ready, 1'b1);

        // Abort together with done
        do_cfg(1'b1, CTR0, 16'd1);
        start_block(PT, CTR0);
        bus.core_done_cipher = 1'b1;
        bus.core_cipherOut   = CT;
        bus.abort            = 1'b1;
        @(negedge clk);
        bus.core_done_cipher = 1'b0;
        bus.abort            = 1'b0;
        chk_b("abort_done_no_valid", bus.out_valid, 1'b0);
        chk_b("abort_done_idle", bus.cfg_ready, 1'b1);
        @(negedge clk);
        chk_b("abort_done_still_no_valid", bus.out_valid, 1'b0);

        // Zero-length session stays idle
        do_cfg(1'b1, CTR0, 16'd0);
        chk_b("nb0_idle", bus.cfg_ready, 1'b1);
        chk_b("nb0_not_busy", bus.busy, 1'b0);
        chk_b("nb0_no_in_ready", bus.in_ready, 1'b0);

        // Asynchronous reset in WAIT
        do_cfg(1'b1, CTR0, 16'd1);
        start_block(PT, CTR0);
        #2 rst_n = 1'b0;
        #1;
        chk_b("arst_core_rst", bus.core_rst, 1'b1);
        chk_b("arst_cfg_ready", bus.cfg_ready, 1'b0);
        chk_b("arst_busy", bus.busy, 1'b0);
        chk("arst_core_key", bus.core_key, 128'h0);
        chk("arst_counter", 128'(bus.core_counterIn), 128'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk_b("arst_cfg_ready_back", bus.cfg_ready, 1'b1);
        chk_b("arst_no_out", bus.out_valid, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
